// File: rtl/dff_bist_pkg.sv
// -----------------------------------------------------------------------------
// dff_bist_pkg
// Shared definitions for the D flip-flop BIST checker:
//   - bist_state_t : controller states (IDLE, INIT, RUN, DRAIN, DONE)
//   - LFSR_W       : pattern generator width
//   - LFSR_TAPS    : feedback tap mask (x^8+x^6+x^5+x^4+1 -> bits 7,5,4,3)
//   - DEFAULT_SEED : default LFSR load value
//   - safe_seed()  : maps an all-zero seed (LFSR lock-up state) to 8'h01
// -----------------------------------------------------------------------------
package dff_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } bist_state_t;

    localparam int                LFSR_W       = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 8'hB8;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'hA5;

    // An all-zero Fibonacci LFSR never leaves zero, so substitute 1.
    function automatic logic [LFSR_W-1:0] safe_seed(input logic [LFSR_W-1:0] s);
        return (s == '0) ? LFSR_W'(1) : s;
    endfunction

endpackage

// File: rtl/dff_bist_lfsr.sv
// -----------------------------------------------------------------------------
// dff_bist_lfsr
// 8-bit Fibonacci LFSR, shifting left with the XOR of the tapped bits fed
// into bit 0. Load has priority over shift.
// Ports:
//   clk   in  clock, rising edge
//   load  in  load state with seed
//   shift in  advance one step
//   seed  in  value loaded by load
//   msb   out current bit 7 (the pattern bit)
// -----------------------------------------------------------------------------
module dff_bist_lfsr
    import dff_bist_pkg::*;
(
    input  logic              clk,
    input  logic              load,
    input  logic              shift,
    input  logic [LFSR_W-1:0] seed,
    output logic              msb
);

    logic [LFSR_W-1:0] state;
    logic              fb;

    assign fb  = ^(state & LFSR_TAPS);
    assign msb = state[LFSR_W-1];

    always_ff @(posedge clk) begin
        if (load) begin
            state <= seed;
        end else if (shift) begin
            state <= {state[LFSR_W-2:0], fb};
        end
    end

endmodule

// File: rtl/dff_bist_checker.sv
// -----------------------------------------------------------------------------
// dff_bist_checker
// Stimulus/response engine for a D flip-flop cell (D, CP, RST, Q). Drives
// the cell from an LFSR pattern, compares Q against a one-cycle reference
// and reports a saturating mismatch count plus pass/fail.
//
// Parameters:
//   PAT_LEN  vectors per run (>=2, even)
//   SEED     LFSR load value (0 is replaced by 8'h01)
//   ERR_W    error counter width
//
// Ports:
//   CP       in  clock, rising edge
//   RST_N    in  synchronous active-low reset
//   START    in  begin a run (only honoured in IDLE)
//   Q_IN     in  Q of the cell under test
//   D_OUT    out cell D input (registered)
//   DUT_RST  out cell RST input, active-high (registered)
//   BUSY     out high in every state except IDLE
//   DONE     out one-cycle end-of-run pulse
//   PASS     out result of last run, held until next accepted START
//   ERR_CNT  out saturating mismatch count
//
// Optional feature, macro DFF_BIST_MIDRST_EN:
//   when defined, DUT_RST is also pulsed during RUN vector PAT_LEN/2 and the
//   reference for the following compare is forced to 0.
// -----------------------------------------------------------------------------
module dff_bist_checker
    import dff_bist_pkg::*;
#(
    parameter int                PAT_LEN = 16,
    parameter logic [LFSR_W-1:0] SEED    = DEFAULT_SEED,
    parameter int                ERR_W   = 8
) (
    input  logic             CP,
    input  logic             RST_N,
    input  logic             START,
    input  logic             Q_IN,
    output logic             D_OUT,
    output logic             DUT_RST,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT
);

    localparam int                VW       = $clog2(PAT_LEN);
    localparam logic [VW-1:0]     V_LAST   = VW'(PAT_LEN - 1);
    localparam logic [VW-1:0]     V_MID    = VW'(PAT_LEN / 2);
    localparam logic [VW-1:0]     V_PRE    = VW'(PAT_LEN / 2 - 1);
    localparam logic [LFSR_W-1:0] SEED_EFF = safe_seed(SEED);

`ifdef DFF_BIST_MIDRST_EN
    localparam logic MIDRST = 1'b1;
`else
    localparam logic MIDRST = 1'b0;
`endif

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        return (c == {ERR_W{1'b1}}) ? c : c + ERR_W'(1);
    endfunction

    bist_state_t      state;
    logic [VW-1:0]    vcnt;
    logic             exp_bit;
    logic             cmp_en;
    logic [ERR_W-1:0] err_next;
    logic             lfsr_load;
    logic             lfsr_shift;
    logic             lfsr_msb;

    // Reset also reloads the LFSR so it holds SEED while idle.
    assign lfsr_load  = !RST_N || (state == ST_IDLE && START);
    // INIT pre-steps so the pattern bit for vector v+1 is ready at the end of v.
    assign lfsr_shift = (state == ST_INIT) || (state == ST_RUN && vcnt != V_LAST);

    dff_bist_lfsr u_lfsr (
        .clk   (CP),
        .load  (lfsr_load),
        .shift (lfsr_shift),
        .seed  (SEED_EFF),
        .msb   (lfsr_msb)
    );

    assign cmp_en = (state == ST_RUN) || (state == ST_DRAIN);

    always_comb begin
        err_next = ERR_CNT;
        if (cmp_en && (Q_IN != exp_bit)) begin
            err_next = sat_inc(ERR_CNT);
        end
    end

    always_ff @(posedge CP) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            vcnt    <= '0;
            exp_bit <= 1'b0;
            D_OUT   <= 1'b0;
            DUT_RST <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            PASS    <= 1'b0;
            ERR_CNT <= '0;
        end else begin
            DONE    <= 1'b0;
            ERR_CNT <= err_next;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        state   <= ST_INIT;
                        vcnt    <= '0;
                        ERR_CNT <= '0;
                        PASS    <= 1'b0;
                        BUSY    <= 1'b1;
                        DUT_RST <= 1'b1;
                        D_OUT   <= 1'b0;
                    end
                end
                // The cell is held in reset this cycle, so Q must read 0 next.
                ST_INIT: begin
                    state   <= ST_RUN;
                    vcnt    <= '0;
                    exp_bit <= 1'b0;
                    DUT_RST <= 1'b0;
                    D_OUT   <= lfsr_msb;
                end
                ST_RUN: begin
                    // A reset pulse in this vector means Q reads 0 next cycle.
                    exp_bit <= (MIDRST && vcnt == V_MID) ? 1'b0 : D_OUT;
                    if (vcnt == V_LAST) begin
                        state   <= ST_DRAIN;
                        D_OUT   <= 1'b0;
                        DUT_RST <= 1'b0;
                    end else begin
                        vcnt    <= vcnt + 1'b1;
                        D_OUT   <= lfsr_msb;
                        DUT_RST <= MIDRST && (vcnt == V_PRE);
                    end
                end
                // Verdict uses the count including the DRAIN compare.
                ST_DRAIN: begin
                    state <= ST_DONE;
                    DONE  <= 1'b1;
                    PASS  <= (err_next == '0);
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dff_bist_checker.sv
// -----------------------------------------------------------------------------
// tb_dff_bist_checker
// Three checker instances share CP/RST_N/START:
//   a : default parameters, cell model ideal or inverted (a_inv)
//   b : ERR_W=4, cell model always inverted (saturation)
//   c : SEED=8'h80 (pattern bit 1 at vector 8), cell model ignores RST
// -----------------------------------------------------------------------------
module tb_dff_bist_checker;

`ifdef DFF_BIST_MIDRST_EN
    localparam bit MID = 1'b1;
`else
    localparam bit MID = 1'b0;
`endif

    logic CP = 1'b0;
    always #5 CP = ~CP;

    logic RST_N;
    logic START;

    // instance a
    logic       a_q_in, a_d, a_rst, a_busy, a_done, a_pass;
    logic [7:0] a_err;
    logic       a_cell = 1'b0;
    logic       a_inv  = 1'b0;
    always @(posedge CP) a_cell <= a_rst ? 1'b0 : a_d;
    assign a_q_in = a_inv ? ~a_cell : a_cell;

    // instance b
    logic       b_q_in, b_d, b_rst, b_busy, b_done, b_pass;
    logic [3:0] b_err;
    logic       b_cell = 1'b0;
    always @(posedge CP) b_cell <= b_rst ? 1'b0 : b_d;
    assign b_q_in = ~b_cell;

    // instance c
    logic       c_q_in, c_d, c_rst, c_busy, c_done, c_pass;
    logic [7:0] c_err;
    logic       c_cell = 1'b0;
    always @(posedge CP) c_cell <= c_d;
    assign c_q_in = c_cell;

    dff_bist_checker u_a (
        .CP(CP), .RST_N(RST_N), .START(START), .Q_IN(a_q_in),
        .D_OUT(a_d), .DUT_RST(a_rst), .BUSY(a_busy), .DONE(a_done),
        .PASS(a_pass), .ERR_CNT(a_err)
    );

    dff_bist_checker #(.ERR_W(4)) u_b (
        .CP(CP), .RST_N(RST_N), .START(START), .Q_IN(b_q_in),
        .D_OUT(b_d), .DUT_RST(b_rst), .BUSY(b_busy), .DONE(b_done),
        .PASS(b_pass), .ERR_CNT(b_err)
    );

    dff_bist_checker #(.SEED(8'h80)) u_c (
        .CP(CP), .RST_N(RST_N), .START(START), .Q_IN(c_q_in),
        .D_OUT(c_d), .DUT_RST(c_rst), .BUSY(c_busy), .DONE(c_done),
        .PASS(c_pass), .ERR_CNT(c_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CP);
        #1;
    endtask

    // Called in an IDLE cycle; ends in the IDLE cycle after DONE.
    task automatic run_once(input string tag, input bit inv, input int restart_v,
                            input int exp_err, input bit exp_pass);
        logic [15:0] dv;
        dv    = '0;
        a_inv = inv;
        START = 1'b1;
        tick;                                   // edge 0 -> INIT
        START = 1'b0;
        chk({tag, " init BUSY"}, a_busy, 1);
        chk({tag, " init DUT_RST"}, a_rst, 1);
        chk({tag, " init D_OUT"}, a_d, 0);
        for (int v = 0; v < 16; v++) begin
            tick;                               // edge v+1 -> RUN vector v
            START = (v == restart_v);
            dv[v] = a_d;
            if (v == 8) begin
                chk({tag, " v8 DUT_RST a"}, a_rst, MID);
                chk({tag, " v8 DUT_RST c"}, c_rst, MID);
                chk({tag, " v8 D_OUT c"}, c_d, 1);
            end
        end
        START = 1'b0;
        chk({tag, " D_OUT v0..3"}, dv[3:0], 4'b0101);
        tick;                                   // edge 17 -> DRAIN
        chk({tag, " drain DONE"}, a_done, 0);
        chk({tag, " drain D_OUT"}, a_d, 0);
        chk({tag, " drain DUT_RST"}, a_rst, 0);
        tick;                                   // edge 18 -> DONE
        chk({tag, " DONE pulse"}, a_done, 1);
        chk({tag, " PASS"}, a_pass, exp_pass);
        chk({tag, " ERR_CNT"}, a_err, exp_err);
        tick;                                   // edge 19 -> IDLE
        chk({tag, " DONE low"}, a_done, 0);
        chk({tag, " BUSY low"}, a_busy, 0);
        chk({tag, " PASS held"}, a_pass, exp_pass);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt, idle_cnt, last_done, bad_gap, late_done;

        RST_N = 1'b0;
        START = 1'b0;
        repeat (3) tick;
        chk("rst D_OUT", a_d, 0);
        chk("rst DUT_RST", a_rst, 0);
        chk("rst BUSY", a_busy, 0);
        chk("rst DONE", a_done, 0);
        chk("rst PASS", a_pass, 0);
        chk("rst ERR_CNT", a_err, 0);
        RST_N = 1'b1;
        tick;

        // ideal cell; b saturates, c sees the ignored reset only with MID
        run_once("ideal", 1'b0, -1, 0, 1'b1);
        chk("b sat ERR_CNT", b_err, 15);
        chk("b PASS", b_pass, 0);
        chk("b DONE low", b_done, 0);
        chk("c ERR_CNT", c_err, MID ? 1 : 0);
        chk("c PASS", c_pass, !MID);
        chk("c BUSY", c_busy, 0);

        run_once("inverted", 1'b1, -1, 17, 1'b0);
        chk("b sat ERR_CNT 2", b_err, 15);

        // START during RUN vector 3 must not disturb anything
        run_once("restart", 1'b0, 3, 0, 1'b1);

        // abort at RUN vector 5
        START = 1'b1;
        tick;
        START = 1'b0;
        repeat (6) tick;                        // now in RUN vector 5
        chk("abort busy before", a_busy, 1);
        RST_N = 1'b0;
        tick;
        RST_N = 1'b1;
        chk("abort D_OUT", a_d, 0);
        chk("abort DUT_RST", a_rst, 0);
        chk("abort BUSY", a_busy, 0);
        chk("abort DONE", a_done, 0);
        chk("abort PASS", a_pass, 0);
        chk("abort ERR_CNT", a_err, 0);
        late_done = 0;
        for (int k = 0; k < 20; k++) begin
            tick;
            if (a_done || a_busy) late_done++;
        end
        chk("abort no DONE", late_done, 0);
        run_once("after abort", 1'b0, -1, 0, 1'b1);

        // START held for 60 cycles: three runs, one IDLE cycle after each
        a_inv     = 1'b0;
        done_cnt  = 0;
        idle_cnt  = 0;
        last_done = -1;
        bad_gap   = 0;
        START     = 1'b1;
        for (int k = 0; k < 60; k++) begin
            tick;
            if (a_done) begin
                done_cnt++;
                last_done = k;
            end
            if (!a_busy) begin
                idle_cnt++;
                if (k != last_done + 1) bad_gap++;
            end
        end
        START = 1'b0;
        chk("b2b DONE count", done_cnt, 3);
        chk("b2b IDLE count", idle_cnt, 3);
        chk("b2b last DONE", last_done, 58);
        chk("b2b IDLE gap", bad_gap, 0);
        chk("b2b PASS", a_pass, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dff_bist_checker.md
# dff_bist_checker

Self-checking stimulus/response engine for the D flip-flop cell (`D`, `CP`, `RST`, `Q`).
- Drives the cell's data and reset inputs from an on-chip LFSR pattern.
- Samples `Q` and compares it against a one-cycle reference model.
- Counts mismatches and reports pass or fail.
- Replaces the open-loop simulation stimulus with a synthesizable driver and checker for silicon or FPGA bring-up of the flip-flop primitive.

## Interface
Parameters:
- `PAT_LEN`, 16: number of data vectors per run (≥2, even).
- `SEED`, 8'hA5: LFSR load value. A value of 0 is replaced by 8'h01.
- `ERR_W`, 8: width of the error counter.

Ports:
- `CP`  in  1  clock. All logic is on the rising edge.
- `RST_N`  in  1  reset. Synchronous, active-low.
- `START`  in  1  begins a run. Sampled only in IDLE.
- `Q_IN`  in  1  `Q` output of the cell under test.
- `D_OUT`  out  1  drives the cell's `D` input. Registered.
- `DUT_RST`  out  1  drives the cell's `RST` input, active-high. Registered.
- `BUSY`  out  1  high in every state except IDLE.
- `DONE`  out  1  one-cycle pulse at the end of a run.
- `PASS`  out  1  result of the last run. Held until the next accepted `START`.
- `ERR_CNT`  out  `ERR_W`  mismatch count of the last or current run. Saturating.

## Operation
- FSM states and transitions: IDLE → INIT → RUN → DRAIN → DONE → IDLE.
- **IDLE**
  - `START`=1 loads the LFSR with `SEED`, clears `ERR_CNT`, `PASS` and the vector counter, then moves to INIT.
- **INIT** (1 cycle)
  - `DUT_RST`=1 and `D_OUT`=0.
  - Expected register `exp` is loaded with 0.
- **RUN** (`PAT_LEN` cycles, vector index v = 0..`PAT_LEN`-1)
  - `D_OUT` = LFSR bit 7.
  - LFSR shifts left each cycle with feedback b7^b5^b4^b3 (polynomial x^8+x^6+x^5+x^4+1).
  - Each cycle compares `Q_IN` with `exp`, then loads `exp` with the current `D_OUT`.
- **DRAIN** (1 cycle)
  - Final compare.
  - `D_OUT`=0 and `DUT_RST`=0.
- **DONE** (1 cycle)
  - `DONE`=1.
  - `PASS` = (`ERR_CNT`==0), including any mismatch found in DRAIN.
- Compares per run: `PAT_LEN`+1 (every RUN cycle plus DRAIN).
- A mismatch increments `ERR_CNT`. The counter saturates at 2^`ERR_W`-1.
- `START` outside IDLE is ignored.
- `START` held high causes back-to-back runs, each separated by exactly one IDLE cycle.

## Timing
- Reset values: `D_OUT`=0, `DUT_RST`=0, `BUSY`=0, `DONE`=0, `PASS`=0, `ERR_CNT`=0. FSM is in IDLE and the LFSR holds `SEED`.
- `RST_N` low mid-run: the next edge forces every output to its reset value and the FSM to IDLE. No `DONE` pulse is produced for the aborted run.
- Latency, with edge 0 being the edge that samples `START`:
  - INIT occupies the cycle after edge 0.
  - RUN occupies edges 1..`PAT_LEN`.
  - DRAIN follows at edge `PAT_LEN`+1.
  - `DONE` is high in the cycle after edge `PAT_LEN`+2. For `PAT_LEN`=16, `DONE` is high in the cycle following edge 18.
- Reference model: `Q_IN` in cycle k+1 must equal `D_OUT` in cycle k. The exception is a cycle following `DUT_RST`=1, where `Q_IN` must be 0.
- `ERR_CNT` updates on the edge ending the compare cycle.

## Configuration
- `DFF_BIST_MIDRST_EN`
  - **Defined:** in RUN at vector v=`PAT_LEN`/2, `DUT_RST`=1 for that one cycle and `exp` is loaded with 0 instead of `D_OUT`. This exercises a reset pulse in the middle of the data stream.
  - **Undefined:** `DUT_RST` is asserted only in INIT.
  - The compare count and the latency are identical in both cases.

## Structure
- Package `dff_bist_pkg`:
  - State enum: IDLE, INIT, RUN, DRAIN, DONE.
  - LFSR width 8 and the tap mask 8'hB8, i.e. bits 7, 5, 4, 3.
  - Default seed 8'hA5.
- Sub-module `dff_bist_lfsr`:
  - 8-bit Fibonacci LFSR with `load`, `shift` and `seed` inputs.
  - Output `msb`.

## Test plan
- Ideal flip-flop model with the macro off, `PAT_LEN`=16, `SEED`=8'hA5:
  - First four `D_OUT` values in RUN are 1,0,1,0.
  - `DONE` pulses once, in the cycle after edge 18.
  - `PASS`=1 and `ERR_CNT`=0.
- `Q_IN` tied to the inverted ideal `Q`:
  - `ERR_CNT`=17 and `PASS`=0.
  - Repeated with `ERR_W`=4: `ERR_CNT` saturates at 15.
- `START` pulsed again at RUN vector 3 → ignored, and `DONE` timing is unchanged.
- `START` held high for 60 cycles → three complete runs, each followed by a single IDLE cycle.
- `RST_N` low for 1 cycle at RUN vector 5:
  - Next cycle: all outputs are 0 and `BUSY`=0.
  - A subsequent `START` reproduces `D_OUT` 1,0,1,0.
- Macro defined, ideal flip-flop: `DUT_RST`=1 at vector 8, `PASS`=1.
  - Flip-flop model that ignores `RST` with a data value of 1 at vector 8 → `ERR_CNT`=1.
  - Same stimulus with the macro undefined → `ERR_CNT`=0.
